// File: rtl/seg_pkg.sv
// Shared types and elaboration helpers for the segment scan driver.
package seg_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } seg_state_t;

  function automatic int unsigned slot_cycles(int unsigned clk_hz,
                                              int unsigned scan_hz,
                                              int unsigned num_digits);
    return clk_hz / (scan_hz * num_digits);
  endfunction

  function automatic int unsigned nib_idx_w(int unsigned num_digits);
    return $clog2(num_digits);
  endfunction

endpackage

// File: rtl/seg_scan_slot_timer.sv
// Per-digit slot sequencer: GAP_CYCLES of blanking followed by SLOT-GAP_CYCLES of display.
module scan_slot_timer
  import seg_pkg::*;
#(
  parameter int unsigned SLOT       = 5,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  output logic latch_stb,
  output logic show,
  output logic slot_end
);

  localparam int unsigned SHOW_CYCLES = SLOT - GAP_CYCLES;
  localparam int unsigned CW          = $clog2(SLOT + 1);

  seg_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gap_last, show_last;

  assign gap_last  = (cnt == CW'(GAP_CYCLES - 1));
  assign show_last = (cnt == CW'(SHOW_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GAP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    unique case (state)
      GAP: if (gap_last) begin
        state_nxt = SHOW;
        cnt_nxt   = '0;
      end
      SHOW: if (show_last) begin
        state_nxt = GAP;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = GAP;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    latch_stb = (state == GAP) && gap_last;
    show      = (state == SHOW);
    slot_end  = (state == SHOW) && show_last;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Byte-history display scanner feeding a hex-to-7seg decoder.
// Optional leading-zero digit blanking is enabled with `define SEG_LZ_BLANK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned SCAN_HZ    = 1_000,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  clear,
  output logic [3:0]            hex_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  scan_wrap
);

  localparam int unsigned SLOT = slot_cycles(CLK_HZ, SCAN_HZ, NUM_DIGITS);
  localparam int unsigned IW   = nib_idx_w(NUM_DIGITS);
  localparam int unsigned HW   = NUM_DIGITS * 4;

  if (SLOT <= GAP_CYCLES) begin : g_bad_slot
    $error("seg_scan_driver: SLOT (%0d) must exceed GAP_CYCLES (%0d)", SLOT, GAP_CYCLES);
  end
  if (GAP_CYCLES < 1 || NUM_DIGITS < 2 || (NUM_DIGITS % 2) != 0) begin : g_bad_cfg
    $error("seg_scan_driver: invalid GAP_CYCLES/NUM_DIGITS configuration");
  end

  logic [HW-1:0] hist;
  logic [IW-1:0] idx;
  logic          latch_stb, show, slot_end;
  logic          idx_last, lz_ok;

  scan_slot_timer #(
    .SLOT      (SLOT),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .latch_stb(latch_stb),
    .show     (show),
    .slot_end (slot_end)
  );

  assign idx_last = (idx == IW'(NUM_DIGITS - 1));

  // Shift-and-or keeps the push legal for NUM_DIGITS == 2 (no negative slice bound).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else if (clear) begin
      hist <= '0;
    end else if (byte_valid) begin
      hist <= (hist << 8) | HW'(byte_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      hex_out <= '0;
    end else begin
      if (latch_stb) hex_out <= hist[{idx, 2'b00} +: 4];
      if (slot_end)  idx     <= idx_last ? '0 : idx + 1'b1;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [IW-1:0] top_nz;
  always_comb begin
    top_nz = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (hist[i*4 +: 4] != 4'h0) top_nz = IW'(i);
    end
    lz_ok = (idx <= top_nz);
  end
`else
  assign lz_ok = 1'b1;
`endif

  always_comb begin
    digit_en = '0;
    if (show && lz_ok) digit_en[idx] = 1'b1;
    scan_wrap = slot_end && idx_last;
  end

endmodule
